// File: rtl/noc_run_sequencer_if.sv
// Purpose: control/status bundle between the NoC run sequencer and its surroundings.
// Latency: none (wires only); every sequencer-driven signal is a flop output in the sequencer.
// Backpressure: none; GO is a one-cycle request and is dropped while the sequencer is busy.
// Ports (signals):
//   i_go, i_abort, i_done           requests/completion into the sequencer
//   o_start[NUM_CHANNELS]           one-hot start pulses, bit 0 first
//   o_busy, o_run_idx               activity flag and current 0-based run number
//   o_pass_cnt, o_timeout_cnt       saturating run-outcome counters
//   o_finished, o_aborted           batch-complete pulse and sticky abort flag
interface noc_run_sequencer_if #(
   parameter int NUM_CHANNELS = 2,
   parameter int CNT_W        = 16
);
   logic                    i_go;
   logic                    i_abort;
   logic                    i_done;
   logic [NUM_CHANNELS-1:0] o_start;
   logic                    o_busy;
   logic [CNT_W-1:0]        o_run_idx;
   logic [CNT_W-1:0]        o_pass_cnt;
   logic [CNT_W-1:0]        o_timeout_cnt;
   logic                    o_finished;
   logic                    o_aborted;

   // sequencer side
   modport master (
      input  i_go, i_abort, i_done,
      output o_start, o_busy, o_run_idx, o_pass_cnt, o_timeout_cnt, o_finished, o_aborted
   );

   // controller / observer side
   modport slave (
      output i_go, i_abort, i_done,
      input  o_start, o_busy, o_run_idx, o_pass_cnt, o_timeout_cnt, o_finished, o_aborted
   );
endinterface

// File: rtl/noc_run_sequencer.sv
// Purpose: batch run controller; per run pulses each start channel in turn, waits for DONE
//          (with optional timeout), idles a gap, and repeats NUM_RUNS times.
// Latency: every output is registered; GO at edge t -> o_start[0] high from cycle t+1.
// Backpressure: none; GO is ignored while busy, ABORT ends a batch on the following cycle.
// Ports:
//   i_clk  single clock
//   i_rst  synchronous active-high reset, wins over GO/ABORT
//   bus    noc_run_sequencer_if.master (GO/ABORT/DONE in, START and status out)
module noc_run_sequencer #(
   parameter int NUM_CHANNELS   = 2,
   parameter int NUM_RUNS       = 5,
   parameter int PULSE_CYCLES   = 1,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   noc_run_sequencer_if.master  bus
);

   // Each down-counter-free phase counter runs 0 .. LIMIT-1, so log2(LIMIT) bits suffice.
   localparam int PC_W = (PULSE_CYCLES   > 1) ? $clog2(PULSE_CYCLES)   : 1;
   localparam int WC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GC_W = (GAP_CYCLES     > 1) ? $clog2(GAP_CYCLES)     : 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(NUM_RUNS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PULSE,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t                  r_state;
   logic [PC_W-1:0]         r_pulse_cnt;
   logic [WC_W-1:0]         r_wait_cnt;
   logic [GC_W-1:0]         r_gap_cnt;
   logic [NUM_CHANNELS-1:0] r_start;
   logic                    r_busy;
   logic [CNT_W-1:0]        r_run_idx;
   logic [CNT_W-1:0]        r_pass_cnt;
   logic [CNT_W-1:0]        r_timeout_cnt;
   logic                    r_finished;
   logic                    r_aborted;

   logic w_pulse_last;
   logic w_last_channel;
   logic w_timeout;
   logic w_wait_exit;
   logic w_gap_last;
   logic w_run_end;
   logic w_last_run;

   assign w_pulse_last   = (r_pulse_cnt == PC_W'(PULSE_CYCLES - 1));
   // r_start is one-hot while pulsing, so its top bit marks the final channel
   assign w_last_channel = r_start[NUM_CHANNELS-1];
   // TIMEOUT_CYCLES == 0 disables the timeout: wait for DONE forever
   assign w_timeout      = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == WC_W'(TIMEOUT_CYCLES - 1));
   assign w_wait_exit    = (r_state == S_WAIT_DONE) && (bus.i_done || w_timeout);
   assign w_gap_last     = (r_gap_cnt == GC_W'(GAP_CYCLES - 1));
   // A run is over either at the last gap cycle, or straight out of WAIT_DONE when there is no gap
   assign w_run_end      = (GAP_CYCLES == 0) ? w_wait_exit
                                             : ((r_state == S_GAP) && w_gap_last);
   assign w_last_run     = (r_run_idx == LAST_RUN);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_pulse_cnt   <= '0;
         r_wait_cnt    <= '0;
         r_gap_cnt     <= '0;
         r_start       <= '0;
         r_busy        <= 1'b0;
         r_run_idx     <= '0;
         r_pass_cnt    <= '0;
         r_timeout_cnt <= '0;
         r_finished    <= 1'b0;
         r_aborted     <= 1'b0;
      end else begin
         r_finished <= 1'b0;
         if (r_state == S_IDLE) begin
            // ABORT has no effect here; GO wins even if ABORT is high in the same cycle
            if (bus.i_go) begin
               r_state       <= S_PULSE;
               r_start       <= NUM_CHANNELS'(1);
               r_pulse_cnt   <= '0;
               r_busy        <= 1'b1;
               r_run_idx     <= '0;
               r_pass_cnt    <= '0;
               r_timeout_cnt <= '0;
               r_aborted     <= 1'b0;
            end
         end else if (bus.i_abort) begin
            // abort beats any DONE/timeout/gap event of the same cycle; counters hold
            r_state   <= S_IDLE;
            r_start   <= '0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
         end else begin
            case (r_state)
               S_PULSE: begin
                  if (w_pulse_last) begin
                     r_pulse_cnt <= '0;
                     if (w_last_channel) begin
                        r_state    <= S_WAIT_DONE;
                        r_start    <= '0;
                        r_wait_cnt <= '0;
                     end else begin
                        // next channel starts in the very next cycle, no bubble
                        r_start <= r_start << 1;
                     end
                  end else begin
                     r_pulse_cnt <= r_pulse_cnt + 1'b1;
                  end
               end
               S_WAIT_DONE: begin
                  if (w_wait_exit) begin
                     // DONE coinciding with the timeout still counts as a pass
                     if (bus.i_done) begin
                        if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + 1'b1;
                     end else begin
                        if (r_timeout_cnt != CNT_MAX) r_timeout_cnt <= r_timeout_cnt + 1'b1;
                     end
                     if (GAP_CYCLES != 0) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= '0;
                     end
                  end else begin
                     r_wait_cnt <= r_wait_cnt + 1'b1;
                  end
               end
               S_GAP: begin
                  if (!w_gap_last) r_gap_cnt <= r_gap_cnt + 1'b1;
               end
               default: ;
            endcase

            // End-of-run decision, shared by the gap path and the zero-gap path
            if (w_run_end) begin
               if (w_last_run) begin
                  r_state    <= S_IDLE;
                  r_busy     <= 1'b0;
                  r_finished <= 1'b1;
               end else begin
                  r_state     <= S_PULSE;
                  r_run_idx   <= r_run_idx + 1'b1;
                  r_start     <= NUM_CHANNELS'(1);
                  r_pulse_cnt <= '0;
               end
            end
         end
      end
   end

   assign bus.o_start       = r_start;
   assign bus.o_busy        = r_busy;
   assign bus.o_run_idx     = r_run_idx;
   assign bus.o_pass_cnt    = r_pass_cnt;
   assign bus.o_timeout_cnt = r_timeout_cnt;
   assign bus.o_finished    = r_finished;
   assign bus.o_aborted     = r_aborted;

endmodule
